// File: rtl/vga_pkg.sv
// Shared definitions for the VGA character-terminal text buffer.
// Contents:
//   - screen geometry (COLS x ROWS characters of CHAR_W x CHAR_H pixels)
//   - ASCII control/fill codes used by the buffer
//   - FSM state encoding
//   - address helpers: logical-to-physical row mapping and cell address
package vga_pkg;

    localparam int COLS   = 70;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 9;
    localparam int CHAR_H = 16;
    localparam int CELLS  = COLS * ROWS;

    localparam int ADDR_W = 12;   // enough for CELLS = 2100
    localparam int ROW_W  = 5;    // enough for ROWS-1 = 29
    localparam int COL_W  = 7;    // enough for COLS-1 = 69

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_US = 8'h5F;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        CLR  = 2'd2
    } state_t;

    // Map a logical (on-screen) row to its physical RAM line; the sum never
    // exceeds 2*ROWS-2, so a single conditional subtract replaces the modulo.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                  input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end else begin
            sum = sum;
        end
        return sum[ROW_W-1:0];
    endfunction

    // Linear RAM address of a physical cell.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return (ADDR_W'(row) * ADDR_W'(COLS)) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/vga_text_buf_ram.sv
// text_ram: single-clock 1W1R synchronous RAM holding the character cells.
// A read and a write to the same address in one cycle returns the old
// contents (read-before-write). No reset: the owner clears it explicitly.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - registered read data, valid one cycle after raddr
module text_ram #(
    parameter int DEPTH = 2100,
    parameter int AW    = 12,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; samples the array before this cycle's write lands.
    always_ff @(posedge clk) begin
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/vga_text_buf.sv
// vga_text_buf: character-terminal text buffer and font-ROM address generator.
// Keyboard bytes are written into a COLS x ROWS circular screen (cursor,
// newline, backspace, scrolling). For every pixel coordinate the block
// returns, one cycle later, the character code and the glyph row/column.
// Optional build macro: VGA_CURSOR_EN adds a blinking '_' cursor
// (parameter BLINK_FRAMES sets the half-period in frames).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   key_valid  - key_ascii holds a byte
//   key_ascii  - ASCII byte from keyboard decoder
//   key_ready  - byte accepted when key_valid && key_ready
//   h_addr     - pixel x (0..639 active)
//   v_addr     - pixel y (0..479 active)
//   ascii_out  - character code to font ROM
//   font_row   - v_addr % CHAR_H
//   font_col   - h_addr % CHAR_W
module vga_text_buf
    import vga_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    output logic       key_ready,
    input  logic [9:0] h_addr,
    input  logic [9:0] v_addr,
    output logic [7:0] ascii_out,
    output logic [3:0] font_row,
    output logic [3:0] font_col
);

    // Write side state.
    state_t            state_r, state_s;
    logic [ADDR_W-1:0] cnt_r, cnt_s;
    logic [ADDR_W-1:0] clr_base_r, clr_base_s;
    logic [ROW_W-1:0]  cur_row_r, cur_row_s;
    logic [COL_W-1:0]  cur_col_r, cur_col_s;
    logic [ROW_W-1:0]  top_r, top_s;
    logic              key_ready_r;
    logic              do_nl_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [7:0]        wdata_s;

    // Read side.
    logic [9:0]        char_x_s;
    logic [9:0]        char_y_s;
    logic [3:0]        fcol_s;
    logic              in_range_s;
    logic [ADDR_W-1:0] raddr_s;
    logic [7:0]        rdata_s;
    logic              blank_r;
    logic [3:0]        font_row_r;
    logic [3:0]        font_col_r;
    logic [7:0]        ascii_s;

    text_ram #(
        .DEPTH (CELLS),
        .AW    (ADDR_W),
        .DW    (8)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Next-state logic: INIT fill, byte handling in IDLE, line clear in CLR.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        clr_base_s = clr_base_r;
        cur_row_s  = cur_row_r;
        cur_col_s  = cur_col_r;
        top_s      = top_r;
        do_nl_s    = 1'b0;
        we_s       = 1'b0;
        waddr_s    = {ADDR_W{1'b0}};
        wdata_s    = ASCII_SP;

        case (state_r)
            INIT: begin
                we_s    = 1'b1;
                waddr_s = cnt_r;
                if (cnt_r == ADDR_W'(CELLS - 1)) begin
                    state_s = IDLE;
                    cnt_s   = {ADDR_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            IDLE: begin
                if (key_valid && key_ready_r) begin
                    if ((key_ascii >= 8'h20) && (key_ascii <= 8'h7E)) begin
                        we_s    = 1'b1;
                        waddr_s = cell_addr(phys_row(cur_row_r, top_r), cur_col_r);
                        wdata_s = key_ascii;
                        if (cur_col_r == COL_W'(COLS - 1)) begin
                            do_nl_s = 1'b1;
                        end else begin
                            cur_col_s = cur_col_r + 7'd1;
                        end
                    end else if ((key_ascii == ASCII_LF) || (key_ascii == ASCII_CR)) begin
                        do_nl_s = 1'b1;
                    end else if (key_ascii == ASCII_BS) begin
                        // Backspace never wraps to the previous line.
                        if (cur_col_r != 7'd0) begin
                            cur_col_s = cur_col_r - 7'd1;
                            we_s      = 1'b1;
                            waddr_s   = cell_addr(phys_row(cur_row_r, top_r),
                                                  cur_col_r - 7'd1);
                        end else begin
                            cur_col_s = cur_col_r;
                        end
                    end else begin
                        do_nl_s = 1'b0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: begin
                we_s    = 1'b1;
                waddr_s = clr_base_r + cnt_r;
                if (cnt_r == ADDR_W'(COLS - 1)) begin
                    state_s = IDLE;
                    cnt_s   = {ADDR_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = INIT;
                cnt_s   = {ADDR_W{1'b0}};
            end
        endcase

        // Newline. When scrolling, the old top line becomes the new bottom
        // line, so that is the physical line cleared.
        if (do_nl_s) begin
            cur_col_s = 7'd0;
            if (cur_row_r < ROW_W'(ROWS - 1)) begin
                cur_row_s = cur_row_r + 5'd1;
            end else begin
                if (top_r == ROW_W'(ROWS - 1)) begin
                    top_s = 5'd0;
                end else begin
                    top_s = top_r + 5'd1;
                end
                state_s    = CLR;
                cnt_s      = {ADDR_W{1'b0}};
                clr_base_s = cell_addr(top_r, 7'd0);
            end
        end else begin
            cur_col_s = cur_col_s;
        end
    end

    // Write-side state registers; key_ready mirrors the IDLE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= INIT;
            cnt_r       <= {ADDR_W{1'b0}};
            clr_base_r  <= {ADDR_W{1'b0}};
            cur_row_r   <= 5'd0;
            cur_col_r   <= 7'd0;
            top_r       <= 5'd0;
            key_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            clr_base_r  <= clr_base_s;
            cur_row_r   <= cur_row_s;
            cur_col_r   <= cur_col_s;
            top_r       <= top_s;
            key_ready_r <= (state_s == IDLE);
        end
    end

    // Pixel to character/glyph decomposition and RAM read address.
    always_comb begin
        char_x_s   = h_addr / 10'(CHAR_W);
        char_y_s   = v_addr / 10'(CHAR_H);
        fcol_s     = 4'(h_addr % 10'(CHAR_W));
        in_range_s = (char_x_s < 10'(COLS)) && (char_y_s < 10'(ROWS));
        if (in_range_s) begin
            raddr_s = cell_addr(phys_row(char_y_s[ROW_W-1:0], top_r),
                                char_x_s[COL_W-1:0]);
        end else begin
            raddr_s = {ADDR_W{1'b0}};
        end
    end

    // Glyph coordinates and blanking flag, aligned with the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_r    <= 1'b1;
            font_row_r <= 4'd0;
            font_col_r <= 4'd0;
        end else begin
            blank_r    <= ~in_range_s;
            font_row_r <= v_addr[3:0];
            font_col_r <= fcol_s;
        end
    end

`ifdef VGA_CURSOR_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] frame_cnt_r;
    logic            blink_r;
    logic            cursor_hit_s;
    logic            cursor_r;

    // Frame counter: pixel (0,0) marks a new frame; blink flips every
    // BLINK_FRAMES frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= {FC_W{1'b0}};
            blink_r     <= 1'b0;
        end else if ((h_addr == 10'd0) && (v_addr == 10'd0)) begin
            if (frame_cnt_r == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_r <= {FC_W{1'b0}};
                blink_r     <= ~blink_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Cursor position is logical, so compare against the on-screen cell.
    always_comb begin
        cursor_hit_s = in_range_s
                     && (char_y_s == 10'(cur_row_r))
                     && (char_x_s == 10'(cur_col_r));
    end

    // Cursor substitution flag, aligned with the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_r <= 1'b0;
        end else begin
            cursor_r <= cursor_hit_s && blink_r;
        end
    end

    // Output character select: blank, cursor, or stored character.
    always_comb begin
        if (blank_r) begin
            ascii_s = ASCII_SP;
        end else if (cursor_r) begin
            ascii_s = ASCII_US;
        end else begin
            ascii_s = rdata_s;
        end
    end
`else
    // Output character select: blank or stored character.
    always_comb begin
        if (blank_r) begin
            ascii_s = ASCII_SP;
        end else begin
            ascii_s = rdata_s;
        end
    end
`endif

    assign key_ready = key_ready_r;
    assign ascii_out = ascii_s;
    assign font_row  = font_row_r;
    assign font_col  = font_col_r;

endmodule

// File: tb/tb_vga_text_buf.sv
// Self-checking bench for vga_text_buf: table-driven read-path vectors plus
// directed sequences for init, wrap, backspace, scrolling, reset during a
// line clear and (with VGA_CURSOR_EN) cursor blinking.
module tb_vga_text_buf;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       key_ready;
    logic [9:0] h_addr;
    logic [9:0] v_addr;
    logic [7:0] ascii_out;
    logic [3:0] font_row;
    logic [3:0] font_col;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic [7:0] asc;
        logic [3:0] row;
        logic [3:0] col;
    } vec_t;

    vec_t vecs[10];

    vga_text_buf #(.BLINK_FRAMES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .key_ready (key_ready),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .ascii_out (ascii_out),
        .font_row  (font_row),
        .font_col  (font_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Apply reset, check reset outputs, then count the INIT length.
    task automatic do_reset();
        int n;
        @(negedge clk);
        rst = 1'b1;
        h_addr = 10'd700;
        v_addr = 10'd500;
        repeat (2) @(negedge clk);
        check("rst_key_ready", int'(key_ready), 0);
        check("rst_ascii", int'(ascii_out), 32'h20);
        check("rst_font_row", int'(font_row), 0);
        check("rst_font_col", int'(font_col), 0);
        rst = 1'b0;
        key_valid = 1'b0;
        n = 0;
        while (key_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("init_cycles", n, 2100);
    endtask

    // Offer one byte and wait (bounded) for the handshake.
    task automatic send(input logic [7:0] b);
        int n;
        key_valid = 1'b1;
        key_ascii = b;
        n = 0;
        while (key_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h not accepted", b);
        end
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Present a pixel, compare all three outputs one cycle later.
    task automatic probe(input string nm, input int h, input int v,
                         input int ea, input int er, input int ec);
        h_addr = 10'(h);
        v_addr = 10'(v);
        @(negedge clk);
        check({nm, "_ascii"}, int'(ascii_out), ea);
        check({nm, "_row"}, int'(font_row), er);
        check({nm, "_col"}, int'(font_col), ec);
        h_addr = 10'd700;
        v_addr = 10'd500;
    endtask

    // Character check of one logical cell (pixel offset 1,1 inside it).
    task automatic check_cell(input string nm, input int r, input int c, input int ea);
        h_addr = 10'(c * 9 + 1);
        v_addr = 10'(r * 16 + 1);
        @(negedge clk);
        check(nm, int'(ascii_out), ea);
        h_addr = 10'd700;
        v_addr = 10'd500;
    endtask

`ifdef VGA_CURSOR_EN
    task automatic frame_pulse();
        h_addr = 10'd0;
        v_addr = 10'd0;
        @(negedge clk);
        h_addr = 10'd700;
        v_addr = 10'd500;
    endtask
`endif

    initial begin
        int n;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        h_addr    = 10'd700;
        v_addr    = 10'd500;

        vecs[0] = '{h: 10'd9,   v: 10'd5,   asc: 8'h42, row: 4'd5,  col: 4'd0};
        vecs[1] = '{h: 10'd17,  v: 10'd5,   asc: 8'h42, row: 4'd5,  col: 4'd8};
        vecs[2] = '{h: 10'd8,   v: 10'd15,  asc: 8'h41, row: 4'd15, col: 4'd8};
        vecs[3] = '{h: 10'd1,   v: 10'd5,   asc: 8'h41, row: 4'd5,  col: 4'd1};
        vecs[4] = '{h: 10'd18,  v: 10'd0,   asc: 8'h20, row: 4'd0,  col: 4'd0};
        vecs[5] = '{h: 10'd630, v: 10'd0,   asc: 8'h20, row: 4'd0,  col: 4'd0};
        vecs[6] = '{h: 10'd639, v: 10'd479, asc: 8'h20, row: 4'd15, col: 4'd0};
        vecs[7] = '{h: 10'd629, v: 10'd479, asc: 8'h20, row: 4'd15, col: 4'd8};
        vecs[8] = '{h: 10'd700, v: 10'd500, asc: 8'h20, row: 4'd4,  col: 4'd7};
        vecs[9] = '{h: 10'd9,   v: 10'd16,  asc: 8'h20, row: 4'd0,  col: 4'd0};

        // Init and full-screen blank sweep.
        do_reset();
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 70; c++) begin
                check_cell("sweep_blank", r, c, 32'h20);
            end
        end

        // "AB" then read-path vector table.
        send(8'h41);
        send(8'h42);
        for (int i = 0; i < 10; i++) begin
            probe($sformatf("vec%0d", i), int'(vecs[i].h), int'(vecs[i].v),
                  int'(vecs[i].asc), int'(vecs[i].row), int'(vecs[i].col));
        end

        // Backspace to column 0, extra BS is a no-op, BEL is ignored.
        send(8'h08);
        send(8'h08);
        send(8'h08);
        send(8'h07);
        check("bel_key_ready", int'(key_ready), 1);
        send(8'h43);
        check_cell("bs_c_at_0", 0, 0, 32'h43);
        check_cell("bs_blank_1", 0, 1, 32'h20);
        check_cell("bs_blank_2", 0, 2, 32'h20);

        // Line wrap after 70 printable characters.
        do_reset();
        for (int i = 0; i < 70; i++) begin
            send(8'(8'h21 + i));
        end
        send(8'h5A);
        check_cell("wrap_first", 0, 0, 32'h21);
        check_cell("wrap_last", 0, 69, 32'h66);
        check_cell("wrap_z", 1, 0, 32'h5A);
        send(8'h57);
        check_cell("wrap_w", 1, 1, 32'h57);
        send(8'h08);
        check_cell("bs_w_gone", 1, 1, 32'h20);
        send(8'h08);
        check_cell("bs_z_gone", 1, 0, 32'h20);
        send(8'h08);
        send(8'h59);
        check_cell("bs_nowrap_y", 1, 0, 32'h59);
        check_cell("bs_nowrap_prev", 0, 69, 32'h66);

        // Scrolling: 'M' row 0, 'N' row 1, then newlines down to the bottom.
        do_reset();
        send(8'h4D);
        send(8'h0A);
        send(8'h4E);
        send(8'h0D);
        for (int i = 0; i < 27; i++) begin
            send(8'h0A);
        end
        send(8'h0A);
        n = 0;
        while (key_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("clr_busy_cycles", n, 70);
        check_cell("scroll_bottom_cleared", 29, 0, 32'h20);
        check_cell("scroll_row1_to_row0", 0, 0, 32'h4E);
        send(8'h51);
        probe("q_row29", 4, 464, 32'h51, 0, 4);

        // 29 more scrolls bring top back around to 0.
        for (int i = 0; i < 29; i++) begin
            send(8'h0A);
        end
        check_cell("topwrap_q", 0, 0, 32'h51);
        check_cell("topwrap_row1", 1, 0, 32'h20);
        check_cell("topwrap_row29", 29, 0, 32'h20);

        // One more scroll past the wrap, then reset in the middle of CLR.
        send(8'h0A);
        repeat (3) @(negedge clk);
        check("clr_key_ready_low", int'(key_ready), 0);
        check_cell("postwrap_row29", 29, 0, 32'h20);
        key_valid = 1'b1;
        key_ascii = 8'h4B;
        do_reset();
        check_cell("rst_clr_cell0", 0, 0, 32'h20);
        check_cell("rst_clr_cell1", 0, 1, 32'h20);

`ifdef VGA_CURSOR_EN
        // Cursor blink with BLINK_FRAMES=2: frames 0-1 real, 2-3 cursor.
        do_reset();
        send(8'h48);
        check_cell("cur_f0", 0, 1, 32'h20);
        frame_pulse();
        check_cell("cur_f1", 0, 1, 32'h20);
        frame_pulse();
        check_cell("cur_f2", 0, 1, 32'h5F);
        check_cell("cur_f2_other", 0, 0, 32'h48);
        frame_pulse();
        check_cell("cur_f3", 0, 1, 32'h5F);
        frame_pulse();
        check_cell("cur_f4", 0, 1, 32'h20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
